// File: rtl/user_settings_pkg.sv
// ---------------------------------------------------------------------------
// user_settings_pkg
// Shared widths and FSM state encodings for the user-settings arbiter.
// No ports; imported by user_settings_arbiter and rr_pick.
// ---------------------------------------------------------------------------
package user_settings_pkg;

    localparam int USER_ADDR_W = 8;
    localparam int USER_DATA_W = 32;
    localparam int REQ_ID_W    = 3;

    // FSM state encodings (IDLE -> WR_ADDR -> WR_DATA -> HOLD -> IDLE)
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WR_ADDR = 2'd1;
    localparam logic [1:0] ST_WR_DATA = 2'd2;
    localparam logic [1:0] ST_HOLD    = 2'd3;

endpackage

// File: rtl/user_settings_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority picker: the first set bit of valid at
// or above ptr, wrapping modulo NUM_REQ, wins.
// Ports:
//   valid  in  NUM_REQ   request vector
//   ptr    in  REQ_ID_W  search start index (must be < NUM_REQ)
//   grant  out NUM_REQ   one-hot winner (zero when none valid)
//   idx    out REQ_ID_W  winner index
//   any    out 1         at least one request valid
// ---------------------------------------------------------------------------
module rr_pick
    import user_settings_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]  valid,
    input  logic [REQ_ID_W-1:0] ptr,
    output logic [NUM_REQ-1:0]  grant,
    output logic [REQ_ID_W-1:0] idx,
    output logic                any
);

    int best_dist_s;
    int dist_s;

    // Pick the valid requester with the smallest circular distance from ptr.
    always_comb begin
        grant       = '0;
        idx         = '0;
        any         = 1'b0;
        best_dist_s = NUM_REQ;
        dist_s      = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            dist_s = (i + NUM_REQ - int'(ptr)) % NUM_REQ;
            if (valid[i] && (dist_s < best_dist_s)) begin
                best_dist_s = dist_s;
                grant       = '0;
                grant[i]    = 1'b1;
                idx         = REQ_ID_W'(i);
                any         = 1'b1;
            end else begin
                best_dist_s = best_dist_s;
            end
        end
    end

endmodule

// File: rtl/user_settings_arbiter.sv
// ---------------------------------------------------------------------------
// user_settings_arbiter
// Shares one settings-bus write port among NUM_REQ clients. Each accepted
// (user addr, user data) pair is emitted as two registered writes:
// user addr to BASE, then user data to BASE+1, followed by GAP idle cycles.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   req_valid/req_ready    per-requester handshake (ready is one-hot or zero)
//   req_addr/req_data      packed per-requester user address / user data
//   set_stb/addr/data      registered settings-bus write
//   busy                   sequence in progress
//   grant_id               index of the last granted requester
//   grant_count            (only with USER_SETTINGS_ARB_STATS_EN) saturating
//                          transfer counter
// Optional feature macro: USER_SETTINGS_ARB_STATS_EN
// ---------------------------------------------------------------------------
module user_settings_arbiter
    import user_settings_pkg::*;
#(
    parameter int BASE    = 0,
    parameter int NUM_REQ = 4,
    parameter int GAP     = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [USER_ADDR_W*NUM_REQ-1:0] req_addr,
    input  logic [USER_DATA_W*NUM_REQ-1:0] req_data,
    output logic                           set_stb,
    output logic [7:0]                     set_addr,
    output logic [31:0]                    set_data,
    output logic                           busy,
    output logic [REQ_ID_W-1:0]            grant_id
`ifdef USER_SETTINGS_ARB_STATS_EN
    ,
    output logic [15:0]                    grant_count
`endif
);

    localparam logic [7:0] ADDR_REG = 8'(BASE);
    localparam logic [7:0] DATA_REG = 8'(BASE + 1);
    localparam logic [3:0] GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
    localparam logic [REQ_ID_W-1:0] LAST_ID = REQ_ID_W'(NUM_REQ - 1);

    logic [1:0]             state_q, state_d;
    logic [REQ_ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [REQ_ID_W-1:0]    grant_id_q, grant_id_d;
    logic [USER_DATA_W-1:0] cap_data_q, cap_data_d;
    logic [3:0]             gap_cnt_q, gap_cnt_d;
    logic                   set_stb_q, set_stb_d;
    logic [7:0]             set_addr_q, set_addr_d;
    logic [31:0]            set_data_q, set_data_d;
    logic                   busy_q, busy_d;

    logic [NUM_REQ-1:0]     pick_grant_s;
    logic [REQ_ID_W-1:0]    pick_idx_s;
    logic                   pick_any_s;
    logic                   xfer_s;
    logic [USER_ADDR_W-1:0] win_addr_s;
    logic [USER_DATA_W-1:0] win_data_s;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
        .valid (req_valid),
        .ptr   (rr_ptr_q),
        .grant (pick_grant_s),
        .idx   (pick_idx_s),
        .any   (pick_any_s)
    );

    // Ready is offered only in IDLE; a withdrawn valid re-picks immediately.
    always_comb begin
        if (state_q == ST_IDLE) begin
            req_ready = pick_grant_s;
        end else begin
            req_ready = '0;
        end
        xfer_s = pick_any_s && (state_q == ST_IDLE);
    end

    // Mux the winner's payload out of the packed request buses.
    always_comb begin
        win_addr_s = '0;
        win_data_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_grant_s[i]) begin
                win_addr_s = req_addr[i*USER_ADDR_W +: USER_ADDR_W];
                win_data_s = req_data[i*USER_DATA_W +: USER_DATA_W];
            end else begin
                win_addr_s = win_addr_s;
            end
        end
    end

    // Sequencer next-state; set_* are computed one cycle ahead so the
    // registered outputs line up with the WR_ADDR / WR_DATA states.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        cap_data_d = cap_data_q;
        gap_cnt_d  = gap_cnt_q;
        set_stb_d  = 1'b0;
        set_addr_d = set_addr_q;
        set_data_d = set_data_q;
        case (state_q)
            ST_IDLE: begin
                if (xfer_s) begin
                    state_d    = ST_WR_ADDR;
                    grant_id_d = pick_idx_s;
                    rr_ptr_d   = (pick_idx_s == LAST_ID) ? '0 : pick_idx_s + REQ_ID_W'(1);
                    cap_data_d = win_data_s;
                    set_stb_d  = 1'b1;
                    set_addr_d = ADDR_REG;
                    set_data_d = {{(32-USER_ADDR_W){1'b0}}, win_addr_s};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR_ADDR: begin
                state_d    = ST_WR_DATA;
                set_stb_d  = 1'b1;
                set_addr_d = DATA_REG;
                set_data_d = cap_data_q;
            end
            ST_WR_DATA: begin
                if (GAP == 0) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d   = ST_HOLD;
                    gap_cnt_d = GAP_LOAD;
                end
            end
            ST_HOLD: begin
                if (gap_cnt_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Sequencer and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            cap_data_q <= '0;
            gap_cnt_q  <= 4'd0;
            set_stb_q  <= 1'b0;
            set_addr_q <= 8'd0;
            set_data_q <= 32'd0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            cap_data_q <= cap_data_d;
            gap_cnt_q  <= gap_cnt_d;
            set_stb_q  <= set_stb_d;
            set_addr_q <= set_addr_d;
            set_data_q <= set_data_d;
            busy_q     <= busy_d;
        end
    end

    assign set_stb  = set_stb_q;
    assign set_addr = set_addr_q;
    assign set_data = set_data_q;
    assign busy     = busy_q;
    assign grant_id = grant_id_q;

`ifdef USER_SETTINGS_ARB_STATS_EN
    logic [15:0] grant_count_q, grant_count_d;

    // Saturating transfer counter.
    always_comb begin
        if (xfer_s && (grant_count_q != 16'hFFFF)) begin
            grant_count_d = grant_count_q + 16'd1;
        end else begin
            grant_count_d = grant_count_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_count_q <= 16'd0;
        end else begin
            grant_count_q <= grant_count_d;
        end
    end

    assign grant_count = grant_count_q;
`endif

endmodule
